// File: rtl/product_disp_pkg.sv
// product_disp_pkg: shared types and constants for the product display path
package product_disp_pkg;
    typedef enum logic {IDLE, SHIFT} conv_state_t;
    localparam int PROD_WIDTH  = 8;
    localparam int PROD_DIGITS = 3;
    localparam logic [PROD_DIGITS-1:0] BLANK_DEFAULT = {{(PROD_DIGITS-1){1'b1}}, 1'b0};
    function automatic bit digits_fit(input int width, input int digits);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p > ((longint'(1) << width) - 1);
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential binary-to-BCD converter, one double-dabble step per clock
module product_bcd_converter
    import product_disp_pkg::*;
#(
    parameter int WIDTH  = PROD_WIDTH,
    parameter int DIGITS = PROD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;
    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_params
        $error("product_bcd_converter: DIGITS too small for WIDTH");
    end
    conv_state_t state;
    logic [BW-1:0] acc, adj, acc_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic [BW+WIDTH-1:0] work_nx;
    logic [CW-1:0] cnt;
    logic [DIGITS-1:0] blank_nx;
    logic zero_run;
    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
    end
    // the digit carried out of the top never survives: the result always fits
    assign work_nx = {adj, sh} << 1;
    assign acc_nx  = work_nx[BW+WIDTH-1:WIDTH];
    assign sh_nx   = work_nx[WIDTH-1:0];
    always_comb begin
        blank_nx = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (acc_nx[4*i +: 4] == 4'd0);
            blank_nx[i] = zero_run;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            bcd   <= '0;
            blank <= BLANK_RST;
            acc   <= '0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    acc   <= '0;
                    sh    <= bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
            end else begin
                acc <= acc_nx;
                sh  <= sh_nx;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    bcd   <= acc_nx;
                    blank <= blank_nx;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule
